load_store_unit: RTL and testbench

- Sits between the execute stage and data_memory.
- Accepts one load or store request per transaction from the pipeline and computes the effective address.
- Checks funct3 legality, alignment and address range, then drives data_memory's mem_read/mem_write/signed_unsigned/mem_size controls.
- Captures data_memory's registered read_data and returns a single-cycle response; the pipeline stalls on req_ready=0.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data_memory control bundle between the pipeline, the load/store unit and data_memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_store_data;
    logic        resp_valid;
    logic [1:0]  resp_fault;
    logic [31:0] resp_data;
    logic [31:0] fault_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_signed_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset, req_store_data,
        output mem_read_data,
        input  req_ready, resp_valid, resp_fault, resp_data, fault_addr,
        input  mem_addr, mem_write_data, mem_read, mem_write, mem_signed_unsigned, mem_size
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_store_data,
        input  mem_read_data,
        output req_ready, resp_valid, resp_fault, resp_data, fault_addr,
        output mem_addr, mem_write_data, mem_read, mem_write, mem_signed_unsigned, mem_size
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: decodes one request, checks legality/alignment/range, sequences data_memory
// and returns a single-cycle response.
module load_store_unit #(
    parameter int unsigned MEM_DEPTH   = 64,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN   = 2'b01;
    localparam logic [1:0] FAULT_RANGE   = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b11;
    localparam logic [1:0] SIZE_BYTE     = 2'b01;
    localparam logic [1:0] SIZE_HALF     = 2'b10;
    localparam logic [1:0] SIZE_WORD     = 2'b11;

    state_t      state;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_write_data_q;
    logic [1:0]  mem_size_q;
    logic        mem_su_q;
    logic        resp_valid_q;
    logic [1:0]  resp_fault_q;
    logic [31:0] resp_data_q;
    logic [31:0] fault_addr_q;

    logic [31:0] ea;
    logic [1:0]  dec_size;
    logic        dec_unsigned;
    logic        dec_illegal;
    logic        dec_misaligned;
    logic        dec_range;
    logic [1:0]  dec_fault;

    always_comb begin
        dec_size     = SIZE_BYTE;
        dec_unsigned = 1'b0;
        dec_illegal  = 1'b0;
        case (bus.req_funct3)
            3'b000: dec_size = SIZE_BYTE;
            3'b001: dec_size = SIZE_HALF;
            3'b010: dec_size = SIZE_WORD;
            3'b100: begin
                dec_size     = SIZE_BYTE;
                dec_unsigned = 1'b1;
                dec_illegal  = bus.req_is_store;
            end
            3'b101: begin
                dec_size     = SIZE_HALF;
                dec_unsigned = 1'b1;
                dec_illegal  = bus.req_is_store;
            end
            default: dec_illegal = 1'b1;
        endcase

        ea             = bus.req_base + bus.req_offset;
        dec_misaligned = CHECK_ALIGN &&
                         (((dec_size == SIZE_HALF) && ea[0]) ||
                          ((dec_size == SIZE_WORD) && (ea[1:0] != 2'b00)));
        dec_range      = (ea >= MEM_DEPTH);

        if (dec_illegal)         dec_fault = FAULT_ILLEGAL;
        else if (dec_misaligned) dec_fault = FAULT_ALIGN;
        else if (dec_range)      dec_fault = FAULT_RANGE;
        else                     dec_fault = FAULT_NONE;
    end

    // Memory controls are latched at acceptance so they hold from issue through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            mem_size_q       <= '0;
            mem_su_q         <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_fault_q     <= '0;
            resp_data_q      <= '0;
            fault_addr_q     <= '0;
        end else begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (dec_fault != FAULT_NONE) begin
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= dec_fault;
                            fault_addr_q <= ea;
                            resp_data_q  <= '0;
                            state        <= RESP;
                        end else begin
                            mem_addr_q <= ea;
                            mem_size_q <= dec_size;
                            mem_su_q   <= dec_unsigned;
                            if (bus.req_is_store) begin
                                mem_write_data_q <= bus.req_store_data;
                                mem_write_q      <= 1'b1;
                                state            <= WR_ISSUE;
                            end else begin
                                mem_read_q <= 1'b1;
                                state      <= RD_ISSUE;
                            end
                        end
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    resp_data_q  <= bus.mem_read_data;
                    resp_fault_q <= FAULT_NONE;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                WR_ISSUE: begin
                    resp_data_q  <= '0;
                    resp_fault_q <= FAULT_NONE;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    mem_addr_q       <= '0;
                    mem_write_data_q <= '0;
                    mem_size_q       <= '0;
                    mem_su_q         <= 1'b0;
                    resp_fault_q     <= '0;
                    resp_data_q      <= '0;
                    fault_addr_q     <= '0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by reset so an abandoned issue cycle never reaches data_memory.
    assign bus.mem_read            = mem_read_q & ~reset;
    assign bus.mem_write           = mem_write_q & ~reset;
    assign bus.req_ready           = (state == IDLE) & ~reset;
    assign bus.mem_addr            = mem_addr_q;
    assign bus.mem_write_data      = mem_write_data_q;
    assign bus.mem_size            = mem_size_q;
    assign bus.mem_signed_unsigned = mem_su_q;
    assign bus.resp_valid          = resp_valid_q;
    assign bus.resp_fault          = resp_fault_q;
    assign bus.resp_data           = resp_data_q;
    assign bus.fault_addr          = fault_addr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/stall sequences and random traffic
// against a transaction-level model with a byte-array data_memory.
module tb_load_store_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    load_store_unit_if bus();

    load_store_unit #(.MEM_DEPTH(64), .CHECK_ALIGN(1'b1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [1:0]  fault;
        logic [31:0] fa;
        logic [31:0] rdata;
        int          lat;
        logic [1:0]  size;
        logic        su;
        logic [31:0] ea;
    } exp_t;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] data;
        logic [1:0]  fault;
        logic [31:0] fa;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    logic [7:0] dm      [64];
    logic [7:0] ref_mem [64];
    logic       prev_resp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // data_memory stand-in: byte array, registered read_data with size/sign extension
    always @(posedge clk) begin
        int nb;
        logic [31:0] w;
        nb = (bus.mem_size == 2'b01) ? 1 : (bus.mem_size == 2'b10) ? 2 : 4;
        if (bus.mem_write) begin
            for (int i = 0; i < nb; i++)
                if (bus.mem_addr + 32'(i) < 32'd64)
                    dm[int'(bus.mem_addr) + i] <= bus.mem_write_data[8*i +: 8];
        end
        if (bus.mem_read) begin
            w = '0;
            for (int i = 0; i < nb; i++)
                if (bus.mem_addr + 32'(i) < 32'd64)
                    w[8*i +: 8] = dm[int'(bus.mem_addr) + i];
            if (!bus.mem_signed_unsigned && nb == 1) w = {{24{w[7]}}, w[7:0]};
            if (!bus.mem_signed_unsigned && nb == 2) w = {{16{w[15]}}, w[15:0]};
            bus.mem_read_data <= w;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_resp = 1'b0;
        end else begin
            chk("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
            chk("resp_single_pulse", 32'(bus.resp_valid & prev_resp), 32'd0);
            if (bus.req_ready) begin
                chk("idle_quiet", {29'd0, bus.mem_read, bus.mem_write, bus.resp_valid}, 32'd0);
                chk("idle_mem_addr", bus.mem_addr, 32'd0);
            end
            prev_resp = bus.resp_valid;
        end
    end

    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] sd, output exp_t e);
        int nb;
        bit legal;
        logic [31:0] w;
        e.ea   = base + off;
        nb     = 1 << f3[1:0];
        legal  = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e.size = (nb == 1) ? 2'd1 : (nb == 2) ? 2'd2 : 2'd3;
        e.su   = f3[2];
        if (!legal)                         e.fault = 2'd3;
        else if (e.ea % 32'(nb) != 32'd0)   e.fault = 2'd1;
        else if (e.ea >= 32'd64)            e.fault = 2'd2;
        else                                e.fault = 2'd0;
        e.fa    = (e.fault != 2'd0) ? e.ea : 32'd0;
        e.lat   = (e.fault != 2'd0) ? 1 : (st ? 2 : 3);
        e.rdata = '0;
        if (e.fault == 2'd0) begin
            if (st) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(e.ea) + i] = sd[8*i +: 8];
            end else begin
                w = '0;
                for (int i = 0; i < nb; i++) w[8*i +: 8] = ref_mem[int'(e.ea) + i];
                if (!e.su && nb == 1) w = {{24{w[7]}}, w[7:0]};
                if (!e.su && nb == 2) w = {{16{w[15]}}, w[15:0]};
                e.rdata = w;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] off, input logic [31:0] sd, input exp_t e,
                           input bit hold);
        int n, lat, nrd, nwr, rd_cyc, wr_cyc, busy_ready;
        logic [31:0] a_iss, wd_iss, a_resp, rd, fa;
        logic [1:0]  sz_iss, flt;
        logic        su_iss;
        bus.req_is_store   = st;
        bus.req_funct3     = f3;
        bus.req_base       = base;
        bus.req_offset     = off;
        bus.req_store_data = sd;
        bus.req_valid      = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        lat = 0; nrd = 0; nwr = 0; rd_cyc = 0; wr_cyc = 0; busy_ready = 0;
        a_iss = '0; wd_iss = '0; a_resp = '0; rd = '0; fa = '0; sz_iss = '0; flt = '0; su_iss = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (!hold) bus.req_valid = 1'b0;
            if (bus.req_ready) busy_ready++;
            if (bus.mem_read) begin
                nrd++; rd_cyc = c; a_iss = bus.mem_addr;
                sz_iss = bus.mem_size; su_iss = bus.mem_signed_unsigned;
            end
            if (bus.mem_write) begin
                nwr++; wr_cyc = c; a_iss = bus.mem_addr; wd_iss = bus.mem_write_data;
                sz_iss = bus.mem_size; su_iss = bus.mem_signed_unsigned;
            end
            if (bus.resp_valid) begin
                lat = c; flt = bus.resp_fault; rd = bus.resp_data;
                fa = bus.fault_addr; a_resp = bus.mem_addr;
            end
        end
        chk("latency", 32'(lat), 32'(e.lat));
        chk("resp_fault", {30'd0, flt}, {30'd0, e.fault});
        chk("resp_data", rd, e.rdata);
        chk("fault_addr", fa, e.fa);
        chk("busy_ready", 32'(busy_ready), 32'd0);
        chk("read_count", 32'(nrd), 32'(!st && e.fault == 2'd0));
        chk("write_count", 32'(nwr), 32'(st && e.fault == 2'd0));
        if (e.fault == 2'd0) begin
            chk("issue_cycle", 32'(st ? wr_cyc : rd_cyc), 32'd1);
            chk("mem_addr", a_iss, e.ea);
            chk("mem_size", {30'd0, sz_iss}, {30'd0, e.size});
            chk("mem_signed_unsigned", {31'd0, su_iss}, {31'd0, e.su});
            chk("mem_addr_stable", a_resp, e.ea);
            if (st) chk("mem_write_data", wd_iss, sd);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got time limit expired, required run completion");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vt[19];
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        prev_resp = 1'b0;
        foreach (dm[i]) dm[i] = '0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        bus.mem_read_data  = '0;
        bus.req_valid      = 1'b0;
        bus.req_is_store   = 1'b0;
        bus.req_funct3     = '0;
        bus.req_base       = '0;
        bus.req_offset     = '0;
        bus.req_store_data = '0;
        reset = 1'b1;

        //          st  f3      base          off           data          flt    fa      rdata         lat
        vt[0]  = '{1, 3'b010, 32'h10,       32'h4,        32'hDEADBEEF, 2'd0, 32'h0,  32'h0,        2};
        vt[1]  = '{0, 3'b010, 32'h10,       32'h4,        32'h0,        2'd0, 32'h0,  32'hDEADBEEF, 3};
        vt[2]  = '{1, 3'b010, 32'h8,        32'h0,        32'h000000F0, 2'd0, 32'h0,  32'h0,        2};
        vt[3]  = '{0, 3'b000, 32'h8,        32'h0,        32'h0,        2'd0, 32'h0,  32'hFFFFFFF0, 3};
        vt[4]  = '{0, 3'b100, 32'h8,        32'h0,        32'h0,        2'd0, 32'h0,  32'h000000F0, 3};
        vt[5]  = '{0, 3'b010, 32'h20,       32'h2,        32'h0,        2'd1, 32'h22, 32'h0,        1};
        vt[6]  = '{0, 3'b001, 32'h40,       32'h0,        32'h0,        2'd2, 32'h40, 32'h0,        1};
        vt[7]  = '{0, 3'b011, 32'h20,       32'h2,        32'h0,        2'd3, 32'h22, 32'h0,        1};
        vt[8]  = '{1, 3'b010, 32'hFFFFFFFC, 32'h8,        32'h12345678, 2'd0, 32'h0,  32'h0,        2};
        vt[9]  = '{0, 3'b010, 32'h0,        32'h4,        32'h0,        2'd0, 32'h0,  32'h12345678, 3};
        vt[10] = '{0, 3'b101, 32'h10,       32'h6,        32'h0,        2'd0, 32'h0,  32'h0000DEAD, 3};
        vt[11] = '{0, 3'b001, 32'h18,       32'hFFFFFFFE, 32'h0,        2'd0, 32'h0,  32'hFFFFDEAD, 3};
        vt[12] = '{1, 3'b100, 32'h0,        32'h0,        32'h0,        2'd3, 32'h0,  32'h0,        1};
        vt[13] = '{1, 3'b001, 32'h41,       32'h0,        32'h0,        2'd1, 32'h41, 32'h0,        1};
        vt[14] = '{1, 3'b000, 32'h3F,       32'h0,        32'h00000080, 2'd0, 32'h0,  32'h0,        2};
        vt[15] = '{0, 3'b000, 32'h3F,       32'h0,        32'h0,        2'd0, 32'h0,  32'hFFFFFF80, 3};
        vt[16] = '{0, 3'b000, 32'h40,       32'h0,        32'h0,        2'd2, 32'h40, 32'h0,        1};
        vt[17] = '{1, 3'b010, 32'h3C,       32'h0,        32'hA5A55A5A, 2'd0, 32'h0,  32'h0,        2};
        vt[18] = '{0, 3'b010, 32'h3C,       32'h0,        32'h0,        2'd0, 32'h0,  32'hA5A55A5A, 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_read", 32'(bus.mem_read), 32'd0);
        chk("reset_mem_write", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(bus.req_ready), 32'd1);
        chk("post_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("post_reset_mem_addr", bus.mem_addr, 32'd0);
        chk("post_reset_resp_fault", {30'd0, bus.resp_fault}, 32'd0);
        chk("post_reset_resp_data", bus.resp_data, 32'd0);
        chk("post_reset_fault_addr", bus.fault_addr, 32'd0);

        for (int i = 0; i < 19; i++) begin
            model(vt[i].st, vt[i].f3, vt[i].base, vt[i].off, vt[i].data, e);
            e.fault = vt[i].fault;
            e.fa    = vt[i].fa;
            e.rdata = vt[i].rdata;
            e.lat   = vt[i].lat;
            run_txn(vt[i].st, vt[i].f3, vt[i].base, vt[i].off, vt[i].data, e, (i % 2) == 1);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);

        // reset landing on the write-issue cycle abandons the store
        bus.req_is_store   = 1'b1;
        bus.req_funct3     = 3'b010;
        bus.req_base       = 32'h30;
        bus.req_offset     = 32'h0;
        bus.req_store_data = 32'hCAFEF00D;
        bus.req_valid      = 1'b1;
        chk("rst_seq_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_seq_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_seq_mem_read", 32'(bus.mem_read), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_seq_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rst_seq_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        chk("rst_seq_resp_valid2", 32'(bus.resp_valid), 32'd0);
        chk("rst_seq_mem_word", {dm[51], dm[50], dm[49], dm[48]},
            {ref_mem[51], ref_mem[50], ref_mem[49], ref_mem[48]});

        for (int k = 0; k < 150; k++) begin
            bit st;
            bit hold;
            logic [2:0] f3;
            logic [31:0] base, off, sd;
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                f3 = 3'($urandom);
            end else begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
                if (st) f3[2] = 1'b0;
            end
            base = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 72));
            off  = 32'($urandom_range(0, 16)) - 32'd8;
            sd   = $urandom;
            hold = 1'($urandom_range(0, 1));
            model(st, f3, base, off, sd, e);
            run_txn(st, f3, base, off, sd, e, hold);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.req_valid = 1'b0;
        @(negedge clk);

        for (int w = 0; w < 16; w++)
            chk("mem_image", {dm[4*w+3], dm[4*w+2], dm[4*w+1], dm[4*w]},
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
